// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Issue/stall control for an in-order pipeline. A 32-entry scoreboard tracks
// registers with pending writes. Decode may hand its instruction to execute
// only when all of the following hold:
//   - no source register is pending (RAW);
//   - the destination register is not pending (WAW);
//   - the in-flight window has room;
//   - no redirect (flush) is in progress.
// A writeback retiring in the same cycle bypasses the hazard on its register.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid_i               decoded instruction present in ID
//   id_rs1_i, id_rs2_i       source register indices
//   id_use_rs1_i/_rs2_i      source actually read
//   id_rd_i, id_wr_rd_i      destination index / instruction writes rd
//   ex_ready_i               execute can accept this cycle
//   wb_valid_i, wb_rd_i,
//   wb_wr_i                  retire strobe, its rd, and whether it wrote rd
//   flush_i                  redirect: kills all in-flight and ID state
//   issue_o                  ID instruction moves to EX this cycle
//   stall_o                  ID must hold its instruction
//   busy_o                   scoreboard, bit r = register r pending
//   inflight_o               issued but not yet retired instructions
//   stall_cnt_o              saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MAX_INFLIGHT = 3,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid_i,
    input  logic [4:0]             id_rs1_i,
    input  logic [4:0]             id_rs2_i,
    input  logic                   id_use_rs1_i,
    input  logic                   id_use_rs2_i,
    input  logic [4:0]             id_rd_i,
    input  logic                   id_wr_rd_i,
    input  logic                   ex_ready_i,
    input  logic                   wb_valid_i,
    input  logic [4:0]             wb_rd_i,
    input  logic                   wb_wr_i,
    input  logic                   flush_i,
    output logic                   issue_o,
    output logic                   stall_o,
    output logic [31:0]            busy_o,
    output logic [2:0]             inflight_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    logic [31:0]            busy_reg;
    logic [31:0]            busy_next;
    logic [31:0]            hazard;
    logic [31:1]            retire_hit;
    logic [31:1]            set_hit;
    logic [2:0]             inflight_reg;
    logic [2:0]             inflight_next;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;
    logic [STALL_CNT_W-1:0] stall_cnt_next;

    logic raw;
    logic waw;
    logic full;
    logic issue;
    logic stall;
    logic retire_eff;

    // -------------------------------------------------------------------------
    // Per-register scoreboard slice. x0 is hardwired: never pending, never a
    // hazard, so its slice is not generated at all.
    // -------------------------------------------------------------------------
    assign hazard[0]    = 1'b0;
    assign busy_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_sb
            assign retire_hit[gi] = wb_valid_i && wb_wr_i && (wb_rd_i == 5'(gi));
            assign set_hit[gi]    = issue && id_wr_rd_i && (id_rd_i == 5'(gi));

            // A register retiring this cycle is already safe to read.
            assign hazard[gi] = busy_reg[gi] && !retire_hit[gi];

            // Flush wins; otherwise a new writer outranks a retiring one, since
            // the new write is the younger and still outstanding.
            always_comb begin
                busy_next[gi] = busy_reg[gi];
                if (flush_i) begin
                    busy_next[gi] = 1'b0;
                end else if (set_hit[gi]) begin
                    busy_next[gi] = 1'b1;
                end else if (retire_hit[gi]) begin
                    busy_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Issue decision
    // -------------------------------------------------------------------------
    assign raw  = (id_use_rs1_i && hazard[id_rs1_i]) ||
                  (id_use_rs2_i && hazard[id_rs2_i]);
    // hazard[0] is constant zero, so the rd!=0 term is implied; kept explicit
    // to make the x0 exemption obvious at this point.
    assign waw  = id_wr_rd_i && (id_rd_i != 5'd0) && hazard[id_rd_i];
    // A retire frees a slot in the same cycle, so a full window still admits.
    assign full = (inflight_reg == MAX_CNT) && !wb_valid_i;

    assign issue = id_valid_i && ex_ready_i && !raw && !waw && !full && !flush_i;
    assign stall = id_valid_i && !issue && !flush_i;

    // -------------------------------------------------------------------------
    // In-flight counter. A retire seen with nothing outstanding is spurious
    // and dropped so the counter never wraps below zero.
    // -------------------------------------------------------------------------
    assign retire_eff = wb_valid_i && (inflight_reg != 3'd0);

    always_comb begin
        inflight_next = inflight_reg;
        if (flush_i) begin
            inflight_next = 3'd0;
        end else begin
            unique case ({issue, retire_eff})
                2'b10:   inflight_next = inflight_reg + 3'd1;
                2'b01:   inflight_next = inflight_reg - 3'd1;
                default: inflight_next = inflight_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Stall counter: saturates at all-ones, deliberately ignores flush so it
    // reflects total lost cycles across redirects.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers; reset overrides flush, issue and retire.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg      <= '0;
            inflight_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            busy_reg      <= busy_next;
            inflight_reg  <= inflight_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign issue_o     = issue;
    assign stall_o     = stall;
    assign busy_o      = busy_reg;
    assign inflight_o  = inflight_reg;
    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Table of per-cycle vectors: each row holds the inputs for one cycle, the
// expected combinational issue/stall in that cycle, and the expected
// registered state after the following rising edge. Rows are pushed to a
// scoreboard queue when driven and popped once the edge has happened.
// A short stall counter width keeps the saturation run brief.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MAXI = 3;
    localparam int SCW  = 8;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wr;
        logic        rdy;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        wbwr;
        logic        fl;
        logic        e_iss;
        logic        e_stl;
        logic [31:0] e_busy;
        logic [2:0]  e_inf;
        logic [SCW-1:0] e_sc;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           id_valid_i;
    logic [4:0]     id_rs1_i;
    logic [4:0]     id_rs2_i;
    logic           id_use_rs1_i;
    logic           id_use_rs2_i;
    logic [4:0]     id_rd_i;
    logic           id_wr_rd_i;
    logic           ex_ready_i;
    logic           wb_valid_i;
    logic [4:0]     wb_rd_i;
    logic           wb_wr_i;
    logic           flush_i;
    logic           issue_o;
    logic           stall_o;
    logic [31:0]    busy_o;
    logic [2:0]     inflight_o;
    logic [SCW-1:0] stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[$];
    vec_t sb_q[$];

    hazard_ctrl #(
        .MAX_INFLIGHT(MAXI),
        .STALL_CNT_W (SCW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid_i  (id_valid_i),
        .id_rs1_i    (id_rs1_i),
        .id_rs2_i    (id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i),
        .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i     (id_rd_i),
        .id_wr_rd_i  (id_wr_rd_i),
        .ex_ready_i  (ex_ready_i),
        .wb_valid_i  (wb_valid_i),
        .wb_rd_i     (wb_rd_i),
        .wb_wr_i     (wb_wr_i),
        .flush_i     (flush_i),
        .issue_o     (issue_o),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .inflight_o  (inflight_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst_v, input logic v, input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic wr,
        input logic rdy, input logic wbv, input logic [4:0] wbrd, input logic wbwr,
        input logic fl, input logic e_iss, input logic e_stl, input logic [31:0] e_busy,
        input logic [2:0] e_inf, input logic [SCW-1:0] e_sc);
        vec_t r;
        r.rst = rst_v; r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        r.rd = rd; r.wr = wr; r.rdy = rdy; r.wbv = wbv; r.wbrd = wbrd; r.wbwr = wbwr;
        r.fl = fl; r.e_iss = e_iss; r.e_stl = e_stl; r.e_busy = e_busy;
        r.e_inf = e_inf; r.e_sc = e_sc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check combinational outputs mid-cycle, then
    // pop the scoreboard entry and check registered state after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        rst          = v.rst;
        id_valid_i   = v.v;
        id_rs1_i     = v.rs1;
        id_use_rs1_i = v.u1;
        id_rs2_i     = v.rs2;
        id_use_rs2_i = v.u2;
        id_rd_i      = v.rd;
        id_wr_rd_i   = v.wr;
        ex_ready_i   = v.rdy;
        wb_valid_i   = v.wbv;
        wb_rd_i      = v.wbrd;
        wb_wr_i      = v.wbwr;
        flush_i      = v.fl;
        sb_q.push_back(v);
        #3;
        chk({tag, ".issue"}, 32'(issue_o), 32'(v.e_iss));
        chk({tag, ".stall"}, 32'(stall_o), 32'(v.e_stl));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".busy"},     busy_o,            e.e_busy);
        chk({tag, ".inflight"}, 32'(inflight_o),   32'(e.e_inf));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(e.e_sc));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst v rs1 u1 rs2 u2 rd wr rdy wbv wbrd wbwr fl | iss stl busy inf sc
        // reset, idle
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0,  0, 0, 32'h0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0,  0, 0, 32'h0,   0, 0));
        // addi x5 issues; add x6,x5,x0 stalls twice; retire x5 bypasses
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,  5, 1, 1, 0, 0, 0, 0,  1, 0, 32'h20,  1, 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 1,  6, 1, 1, 0, 0, 0, 0,  0, 1, 32'h20,  1, 1));
        tbl.push_back(mk(0, 1, 5, 1, 0, 1,  6, 1, 1, 0, 0, 0, 0,  0, 1, 32'h20,  1, 2));
        tbl.push_back(mk(0, 1, 5, 1, 0, 1,  6, 1, 1, 1, 5, 1, 0,  1, 0, 32'h40,  1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 6, 1, 0,  0, 0, 32'h0,   0, 2));
        // fill window with x1,x2,x3; x8 stalls on full; retire x1 lets it in
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0,  1, 0, 32'h2,   1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0, 0,  1, 0, 32'h6,   2, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  3, 1, 1, 0, 0, 0, 0,  1, 0, 32'hE,   3, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  8, 1, 1, 0, 0, 0, 0,  0, 1, 32'hE,   3, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  8, 1, 1, 1, 1, 1, 0,  1, 0, 32'h10C, 3, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 2, 1, 0,  0, 0, 32'h108, 2, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 3, 1, 0,  0, 0, 32'h100, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 8, 1, 0,  0, 0, 32'h0,   0, 3));
        // write x0 never sets busy; read x0 never stalls
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0,  1, 0, 32'h0,   1, 3));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 10, 1, 1, 0, 0, 0, 0,  1, 0, 32'h400, 2, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 0,  0, 0, 32'h400, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1,10, 1, 0,  0, 0, 32'h0,   0, 3));
        // WAW on x7, then ex not ready
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  7, 1, 1, 0, 0, 0, 0,  1, 0, 32'h80,  1, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  7, 1, 1, 0, 0, 0, 0,  0, 1, 32'h80,  1, 4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0,  0, 1, 32'h80,  1, 5));
        // flush with an instruction in ID: no issue, no stall, state cleared
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 1,  0, 0, 32'h0,   0, 5));
        // retire x4 and reissue writer of x4 in one cycle
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  4, 1, 1, 0, 0, 0, 0,  1, 0, 32'h10,  1, 5));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  4, 1, 1, 1, 4, 1, 0,  1, 0, 32'h10,  1, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 4, 1, 0,  0, 0, 32'h0,   0, 5));
        // spurious retire with nothing in flight: no underflow
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 4, 1, 0,  0, 0, 32'h0,   0, 5));
        // retire that did not write rd gives no bypass and clears nothing
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  9, 1, 1, 0, 0, 0, 0,  1, 0, 32'h200, 1, 5));
        tbl.push_back(mk(0, 1, 9, 1, 0, 0, 13, 1, 1, 1, 9, 0, 0,  0, 1, 32'h200, 0, 6));
        // reset overrides retire and flush in the same cycle
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 9, 1, 1,  0, 0, 32'h0,   0, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
            $display("tx v%0d iss=%0d stl=%0d busy=%h inf=%0d sc=%0d",
                     i, issue_o, stall_o, busy_o, inflight_o, stall_cnt_o);
        end

        // Saturation: hold a RAW stall for 2^SCW+5 cycles
        apply(mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 32'h20, 1, 0), "sat.setup");
        for (int k = 1; k <= (1 << SCW) + 5; k++) begin
            logic [SCW-1:0] exp_sc;
            exp_sc = (k >= (1 << SCW) - 1) ? {SCW{1'b1}} : SCW'(k);
            apply(mk(0, 1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 1, 32'h20, 1, exp_sc),
                  $sformatf("sat%0d", k));
        end
        $display("tx sat done sc=%0d", stall_cnt_o);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0), "sat.rst");
        $display("tx sat.rst iss=%0d stl=%0d busy=%h inf=%0d sc=%0d",
                 issue_o, stall_o, busy_o, inflight_o, stall_cnt_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 3, giving the maximum number of issued, unretired instructions (range 1..7).
REQ-002 SHALL have parameter STALL_CNT_W, default 16, giving the width of the stall counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_valid_i  in  1  decoded instruction present in ID.
REQ-007 id_rs1_i / id_rs2_i  in  5 each  source register indices from the decode bus.
REQ-008 id_use_rs1_i / id_use_rs2_i  in  1 each  source is actually read (format-dependent).
REQ-009 id_rd_i  in  5  destination index; id_wr_rd_i  in  1  instruction writes rd.
REQ-010 ex_ready_i  in  1  execute stage can accept an instruction this cycle.
REQ-011 wb_valid_i  in  1  an instruction retires this cycle; wb_rd_i  in  5  its rd; wb_wr_i  in  1  it wrote rd.
REQ-012 flush_i  in  1  branch/jump redirect; kills all in-flight and ID state.
REQ-013 issue_o  out  1  ID instruction transfers to EX this cycle.
REQ-014 stall_o  out  1  ID must hold (id_valid_i high and issue_o low).
REQ-015 busy_o  out  32  scoreboard; bit r set means register r has a pending write.
REQ-016 inflight_o  out  3  number of issued, unretired instructions.
REQ-017 stall_cnt_o  out  STALL_CNT_W  saturating count of stalled cycles.

Function
REQ-018 hazard_r(r) SHALL be busy_o[r] and not (wb_valid_i and wb_wr_i and wb_rd_i==r), so a same-cycle retire bypasses the hazard.
REQ-019 raw SHALL be (id_use_rs1_i and hazard_r(id_rs1_i)) or (id_use_rs2_i and hazard_r(id_rs2_i)).
REQ-020 waw SHALL be id_wr_rd_i and id_rd_i!=0 and hazard_r(id_rd_i).
REQ-021 full SHALL be inflight_o==MAX_INFLIGHT and not wb_valid_i.
REQ-022 issue_o SHALL be combinational: id_valid_i and ex_ready_i and not raw, waw, full or flush_i.
REQ-023 stall_o SHALL equal id_valid_i and not issue_o and not flush_i.
REQ-024 Register x0 SHALL never be set busy and SHALL never cause a hazard.
REQ-025 Scoreboard next state per bit r: clear if a retire writes r; then set if an issue with id_wr_rd_i writes r (r!=0). Set SHALL take priority when both apply to the same r.
REQ-026 The inflight counter SHALL be +1 on issue only, -1 on retire only, and unchanged on both or neither.
REQ-027 A retire with inflight_o==0 SHALL be ignored; the counter does not underflow.
REQ-028 Flush SHALL take priority over all other updates: next cycle busy_o=0 and inflight_o=0, and issue_o is 0 in the flush cycle.
REQ-029 stall_cnt_o SHALL increment on each cycle stall_o=1 and hold at all-ones.
REQ-030 stall_cnt_o SHALL be unaffected by flush_i.
REQ-031 Latency: a register set in cycle N is visible in busy_o in cycle N+1; a retire clears it in the same cycle through the bypass in REQ-018.

Reset
REQ-032 When rst=1 at a clock edge: busy_o=0, inflight_o=0, stall_cnt_o=0.
REQ-033 Reset SHALL override flush_i, issue and retire in the same cycle.
REQ-034 issue_o and stall_o SHALL remain combinational during reset; the bench drives id_valid_i=0 while rst=1.

Verification
REQ-035 Scenario: issue addi x5 (wr) cycle 0; next instruction add reads x5 with no retire -> stall_o=1 and stall_cnt_o increments each cycle; wb_valid_i=1, wb_rd_i=5 -> issue_o=1 that cycle.
REQ-036 Scenario: three writers x1, x2, x3 issued with no retire (MAX_INFLIGHT=3) -> inflight_o=3; a fourth independent instruction is stalled; a retire in the same cycle -> fourth issues and inflight_o stays 3.
REQ-037 Scenario: an instruction writing x0 is issued -> busy_o stays 0; a following instruction reading x0 issues with no stall.
REQ-038 Scenario: x7 busy, flush_i=1 with id_valid_i=1 -> issue_o=0 and stall_o=0; next cycle busy_o=0 and inflight_o=0.
REQ-039 Scenario: retire x4 and issue a new writer of x4 in the same cycle -> busy_o[4]=1 next cycle and inflight_o unchanged.
REQ-040 Scenario: hold a stall for 2^STALL_CNT_W+5 cycles -> stall_cnt_o saturates at all-ones; rst=1 -> all outputs zero the next cycle.
